spi_frame_tx: RTL and testbench



---
 rtl/spi_frame_tx.sv | 146 ++++++++++++++
 tb/tb_spi_frame_tx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_tx.sv
// spi_frame_tx: valid/ready word serialiser, MSB first, spi_fs high during the MSB period.
// Define SPI_FRAME_TX_PARITY_EN to append an even parity bit after bit 0.
module spi_frame_tx #(
  parameter int WIDTH  = 8,
  parameter int CLKDIV = 4,
  parameter int GAP    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             spi_data,
  output logic             spi_fs,
  output logic             busy
);

`ifdef SPI_FRAME_TX_PARITY_EN
  localparam int L = WIDTH + 1;
`else
  localparam int L = WIDTH;
`endif
  localparam int CNT_MAX = (L > GAP) ? L : GAP;
  localparam int DIV_W   = $clog2(CLKDIV);
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(L - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  // Bits still to send after the one currently on spi_data, next bit at the top.
  logic [L-2:0]     r_shift;

  logic [L-1:0]     w_frame;
  logic             w_accept;
  logic             w_div_last;
  logic             w_shift_adv;

`ifdef SPI_FRAME_TX_PARITY_EN
  function automatic logic f_even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  assign w_frame = {tx_data, f_even_parity(tx_data)};
`else
  assign w_frame = tx_data;
`endif

  // tx_ready is only high in IDLE/DONE, so it doubles as the accept qualifier.
  assign w_accept    = tx_valid && tx_ready;
  assign w_div_last  = (r_div == DIV_LAST);
  assign w_shift_adv = (r_state == S_SHIFT) && w_div_last;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shift <= w_frame[L-2:0];
    end else if (w_shift_adv) begin
      r_shift <= r_shift << 1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_cnt    <= '0;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      spi_data <= 1'b0;
      spi_fs   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state  <= S_IDLE;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          spi_data <= 1'b0;
          spi_fs   <= 1'b0;
          if (w_accept) begin
            r_state  <= S_SHIFT;
            r_div    <= '0;
            r_cnt    <= '0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            spi_fs   <= 1'b1;
            spi_data <= w_frame[L-1];
          end
        end

        S_SHIFT: begin
          if (w_div_last) begin
            r_div  <= '0;
            spi_fs <= 1'b0;
            if (r_cnt == BIT_LAST) begin
              r_cnt    <= '0;
              spi_data <= 1'b0;
              if (GAP == 0) begin
                r_state  <= S_DONE;
                tx_ready <= 1'b1;
                busy     <= 1'b0;
              end else begin
                r_state <= S_GAP;
              end
            end else begin
              r_cnt    <= r_cnt + 1'b1;
              spi_data <= r_shift[L-2];
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        S_GAP: begin
          if (w_div_last) begin
            r_div <= '0;
            if (r_cnt == GAP_LAST) begin
              r_cnt    <= '0;
              r_state  <= S_DONE;
              tx_ready <= 1'b1;
              busy     <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_tx.sv
// Bench for spi_frame_tx: table vectors, hand sequences and a randomized run against a
// cycle-offset reference model (two instances: default and WIDTH=2/CLKDIV=2/GAP=0).
module tb_spi_frame_tx;
`ifdef SPI_FRAME_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int WA = 8, DA = 4, GA = 1;
  localparam int WB = 2, DB = 2, GB = 0;
  localparam int LA = WA + PAR, LB = WB + PAR;
  localparam int RA = (LA + GA) * DA, RB = (LB + GB) * DB;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] a_data;
  logic       a_valid, a_ready, a_sd, a_fs, a_busy;
  logic [1:0] b_data;
  logic       b_valid, b_ready, b_sd, b_fs, b_busy;

  int checks = 0;
  int failures = 0;

  bit          mA_act, mB_act;
  int          mA_t, mB_t;
  logic [31:0] mA_w, mB_w;

  spi_frame_tx #(.WIDTH(WA), .CLKDIV(DA), .GAP(GA)) u_a (
    .clk(clk), .reset(reset), .tx_data(a_data), .tx_valid(a_valid),
    .tx_ready(a_ready), .spi_data(a_sd), .spi_fs(a_fs), .busy(a_busy)
  );

  spi_frame_tx #(.WIDTH(WB), .CLKDIV(DB), .GAP(GB)) u_b (
    .clk(clk), .reset(reset), .tx_data(b_data), .tx_valid(b_valid),
    .tx_ready(b_ready), .spi_data(b_sd), .spi_fs(b_fs), .busy(b_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required to finish");
    $fatal(1, "timeout");
  end

  // Bit k of a frame: data MSB first, then the even parity bit when enabled.
  function automatic bit frame_bit(input logic [31:0] w, input int W, input int k);
    bit p;
    p = 1'b0;
    for (int i = 0; i < W; i++) p ^= w[i];
    if (k < W) return w[W-1-k];
    return p;
  endfunction

  // Expected {tx_ready, busy, spi_fs, spi_data} t cycles after the accepting edge.
  function automatic logic [3:0] m_out(input bit act, input int t, input logic [31:0] w,
                                       input int W, input int D, input int G);
    int L;
    bit bsy, fs, d;
    L   = W + PAR;
    bsy = act && (t < (L + G) * D);
    fs  = act && (t < D);
    d   = 1'b0;
    if (act && t < L * D) d = frame_bit(w, W, t / D);
    return {!bsy, bsy, fs, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    logic [3:0]  ea, eb;
    bit          acc_a, acc_b;
    logic [31:0] wa, wb;
    ea    = m_out(mA_act, mA_t, mA_w, WA, DA, GA);
    eb    = m_out(mB_act, mB_t, mB_w, WB, DB, GB);
    acc_a = (a_valid === 1'b1) && ea[3];
    acc_b = (b_valid === 1'b1) && eb[3];
    wa    = 32'(a_data);
    wb    = 32'(b_data);
    @(posedge clk);
    if (reset === 1'b1) begin
      mA_act = 1'b0;
      mB_act = 1'b0;
    end else begin
      if (acc_a) begin mA_act = 1'b1; mA_t = 0; mA_w = wa; end
      else if (mA_act) mA_t++;
      if (acc_b) begin mB_act = 1'b1; mB_t = 0; mB_w = wb; end
      else if (mB_act) mB_t++;
    end
    #1;
    ea = m_out(mA_act, mA_t, mA_w, WA, DA, GA);
    eb = m_out(mB_act, mB_t, mB_w, WB, DB, GB);
    check($sformatf("modelA t=%0d", mA_t), 32'({a_ready, a_busy, a_fs, a_sd}), 32'(ea));
    check($sformatf("modelB t=%0d", mB_t), 32'({b_ready, b_busy, b_fs, b_sd}), 32'(eb));
  endtask

  task automatic wait_ready_a();
    int n;
    n = 0;
    while (a_ready !== 1'b1 && n < 200) begin cycle(); n++; end
    check("wait_ready_a", 32'(a_ready), 32'(1));
  endtask

  task automatic wait_ready_b();
    int n;
    n = 0;
    while (b_ready !== 1'b1 && n < 200) begin cycle(); n++; end
    check("wait_ready_b", 32'(b_ready), 32'(1));
  endtask

  task automatic send_a(input logic [7:0] w);
    wait_ready_a();
    a_valid = 1'b1;
    a_data  = w;
    cycle();
    a_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0] word;
    int         off;
    logic [3:0] exp;   // {tx_ready, busy, spi_fs, spi_data}
  } vec_t;

  vec_t vecs[$];

  initial begin
    int         ones, rises, n;
    bit         prev;
    logic [7:0] v;
    logic [3:0] ex;

    vecs.push_back('{8'hA5, 0,  4'b0111});
    vecs.push_back('{8'hA5, 3,  4'b0111});
    vecs.push_back('{8'hA5, 4,  4'b0100});
    vecs.push_back('{8'hA5, 8,  4'b0101});
    vecs.push_back('{8'hA5, 12, 4'b0100});
    vecs.push_back('{8'hA5, 20, 4'b0101});
    vecs.push_back('{8'hA5, 28, 4'b0101});
    vecs.push_back('{8'hA5, 31, 4'b0101});
    vecs.push_back('{8'hA5, 32, 4'b0100});
    vecs.push_back('{8'hA5, 35, 4'b0100});
    vecs.push_back('{8'h07, 0,  4'b0110});
    vecs.push_back('{8'h07, 20, 4'b0101});
    vecs.push_back('{8'h07, 28, 4'b0101});
    vecs.push_back('{8'h81, 0,  4'b0111});
    vecs.push_back('{8'h81, 4,  4'b0100});
    vecs.push_back('{8'h81, 28, 4'b0101});
`ifdef SPI_FRAME_TX_PARITY_EN
    vecs.push_back('{8'hA5, 36, 4'b0100});
    vecs.push_back('{8'hA5, 39, 4'b0100});
    vecs.push_back('{8'hA5, 40, 4'b1000});
    vecs.push_back('{8'h07, 32, 4'b0101});
    vecs.push_back('{8'h07, 35, 4'b0101});
    vecs.push_back('{8'h07, 36, 4'b0100});
`else
    vecs.push_back('{8'hA5, 36, 4'b1000});
    vecs.push_back('{8'h07, 32, 4'b0100});
    vecs.push_back('{8'h07, 36, 4'b1000});
`endif

    mA_act = 1'b0; mB_act = 1'b0; mA_t = 0; mB_t = 0; mA_w = '0; mB_w = '0;
    a_valid = 1'b0; a_data = '0; b_valid = 1'b0; b_data = '0;
    reset = 1'b1;
    #2;
    check("reset A outputs", 32'({a_ready, a_busy, a_fs, a_sd}), 32'(4'b1000));
    check("reset B outputs", 32'({b_ready, b_busy, b_fs, b_sd}), 32'(4'b1000));
    cycle();
    cycle();
    reset = 1'b0;
    cycle();

    for (int i = 0; i < vecs.size(); i++) begin
      send_a(vecs[i].word);
      repeat (vecs[i].off) cycle();
      check($sformatf("vec%0d %02h@t0+%0d", i, vecs[i].word, vecs[i].off),
            32'({a_ready, a_busy, a_fs, a_sd}), 32'(vecs[i].exp));
    end

    // Back-to-back: valid held high, 0xFF then 0x00.
    wait_ready_a();
    a_valid = 1'b1;
    a_data  = 8'hFF;
    cycle();
    a_data = 8'h00;
    ones = int'(a_sd);
    for (int k = 1; k <= RA + 1; k++) begin
      cycle();
      if (k <= RA) ones += int'(a_sd);
      if (k == RA) check("b2b ready/fs at t0+RA", 32'({a_ready, a_fs}), 32'(2'b10));
      if (k == RA + 1) check("b2b second fs at t0+RA+1", 32'({a_fs, a_sd}), 32'(2'b10));
    end
    a_valid = 1'b0;
    check("b2b ones in first frame", 32'(ones), 32'(WA * DA));

    // Busy: a 0x3C pulse mid-frame must be ignored.
    send_a(8'h81);
    repeat (10) cycle();
    a_valid = 1'b1;
    a_data  = 8'h3C;
    cycle();
    a_valid = 1'b0;
    check("busy ready held low", 32'(a_ready), 32'(0));
    rises = 0;
    n = 0;
    while (a_ready !== 1'b1 && n < 200) begin
      prev = a_fs;
      cycle();
      if (a_fs && !prev) rises++;
      n++;
    end
    check("busy no extra frame start", 32'(rises), 32'(0));
    repeat (10) cycle();
    check("busy nothing queued", 32'(a_busy), 32'(0));

    // Reset at bit 3 of 0xF0, then a clean 0x55.
    send_a(8'hF0);
    repeat (13) cycle();
    check("pre-reset bit3", 32'({a_busy, a_sd}), 32'(2'b11));
    #3;
    reset = 1'b1;
    mA_act = 1'b0;
    mB_act = 1'b0;
    #1;
    check("async reset outputs", 32'({a_ready, a_busy, a_fs, a_sd}), 32'(4'b1000));
    cycle();
    reset = 1'b0;
    cycle();
    send_a(8'h55);
    v = 8'h55;
    for (int c = 0; c < WA * DA; c++) begin
      if (c % DA == 2) check($sformatf("post-reset 0x55 bit%0d", c / DA), 32'(a_sd), 32'(v[7 - c / DA]));
      cycle();
    end

    // Boundary instance: accept 2'b10, valid held with 2'b11 for the next frame.
    wait_ready_b();
    b_valid = 1'b1;
    b_data  = 2'b10;
    cycle();
    b_data = 2'b11;
    for (int k = 0; k <= RB + 1; k++) begin
      if (k < 2) ex = 4'b0111;
      else if (k < 2 * WB) ex = 4'b0100;
      else if (k < RB) ex = 4'b0101;
      else if (k == RB) ex = 4'b1000;
      else ex = 4'b0111;
      check($sformatf("boundary t0+%0d", k), 32'({b_ready, b_busy, b_fs, b_sd}), 32'(ex));
      cycle();
    end
    b_valid = 1'b0;
    wait_ready_b();

    // Randomized traffic on both instances.
    for (int i = 0; i < 800; i++) begin
      a_valid = ($urandom_range(0, 3) == 0);
      a_data  = 8'($urandom);
      b_valid = ($urandom_range(0, 2) == 0);
      b_data  = 2'($urandom);
      cycle();
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (60) cycle();
    check("final idle A", 32'({a_ready, a_busy}), 32'(2'b10));
    check("final idle B", 32'({b_ready, b_busy}), 32'(2'b10));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
